alu_dispatch: RTL and testbench

- Issue/collect front end for the 32-bit Alu; this block is the producer of its operands and controls (A, B, A_or_L, S_or_U, OpCode) and the consumer of AnswerOne.
- Accepts operation requests over a valid/ready handshake and registers operands and controls into an issue stage that drives the Alu.
- Captures the combinational Alu answer into a result stage and returns it, with its tag, over a second valid/ready handshake.
- Sits between the decode/issue logic of the CPU and the Alu instance.

---
 rtl/alu_pkg.sv | 13 +
 rtl/alu_dispatch_slice.sv | 41 ++++
 rtl/alu_dispatch.sv | 122 ++++++++++++
 tb/tb_alu_dispatch.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared function-field layout and Alu mode constants for the Alu issue/collect front end.
package alu_pkg;

    localparam int FUNC_W      = 4;
    localparam int FUNC_A_OR_L = 3;
    localparam int FUNC_S_OR_U = 2;
    localparam int FUNC_OP_MSB = 1;
    localparam int FUNC_OP_LSB = 0;

    localparam logic ALU_ARITH = 1'b0;
    localparam logic ALU_LOGIC = 1'b1;

endpackage

// File: rtl/alu_dispatch_slice.sv
// Generic valid/ready register slice; flush drops the held entry but leaves the data register alone.
module alu_dispatch_slice #(
    parameter int PAYLOAD_W = 8
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [PAYLOAD_W-1:0] i_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [PAYLOAD_W-1:0] o_data
);

    logic                 r_valid;
    logic [PAYLOAD_W-1:0] r_data;
    logic                 w_load;

    assign o_ready = !r_valid || i_ready;
    assign w_load  = i_valid && o_ready && !i_flush;
    assign o_valid = r_valid;
    assign o_data  = r_data;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else begin
            if (i_flush) begin
                r_valid <= 1'b0;
            end else if (o_ready) begin
                r_valid <= i_valid;
            end
            if (w_load) begin
                r_data <= i_data;
            end
        end
    end

endmodule

// File: rtl/alu_dispatch.sv
// Two-stage issue/collect front end for the 32-bit Alu: S1 drives the Alu, S2 holds its answer.
// Optional activity counters (IssueCount, StallCount) are built when ALU_DISPATCH_STATS_EN is defined.
module alu_dispatch
    import alu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int TAG_W  = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              Flush,
    input  logic              InValid,
    output logic              InReady,
    input  logic [FUNC_W-1:0] InFunc,
    input  logic [DATA_W-1:0] InA,
    input  logic [DATA_W-1:0] InB,
    input  logic [TAG_W-1:0]  InTag,
    output logic [DATA_W-1:0] AluA,
    output logic [DATA_W-1:0] AluB,
    output logic              AluA_or_L,
    output logic              AluS_or_U,
    output logic [1:0]        AluOpCode,
    input  logic [DATA_W-1:0] AluAnswer,
    output logic              OutValid,
    input  logic              OutReady,
    output logic [DATA_W-1:0] OutResult,
    output logic [TAG_W-1:0]  OutTag
`ifdef ALU_DISPATCH_STATS_EN
    ,
    output logic [31:0]       IssueCount,
    output logic [31:0]       StallCount
`endif
);

    localparam int S1_W = TAG_W + FUNC_W + 2 * DATA_W;
    localparam int S2_W = TAG_W + DATA_W;

    logic              r_rst_done;
    logic              w_in_valid;
    logic              w_s1_ready;
    logic              w_s1_valid;
    logic              w_s2_ready;
    logic [S1_W-1:0]   w_s1_q;
    logic [S2_W-1:0]   w_s2_q;
    logic [DATA_W-1:0] w_s1_a;
    logic [DATA_W-1:0] w_s1_b;
    logic [FUNC_W-1:0] w_s1_func;
    logic [TAG_W-1:0]  w_s1_tag;

    // Holds InReady low through reset and for the release cycle itself.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_rst_done <= 1'b0;
        end else begin
            r_rst_done <= 1'b1;
        end
    end

    assign w_in_valid = InValid && r_rst_done;
    assign InReady    = w_s1_ready && !Flush && r_rst_done;

    alu_dispatch_slice #(
        .PAYLOAD_W(S1_W)
    ) u_s1 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_flush (Flush),
        .i_valid (w_in_valid),
        .o_ready (w_s1_ready),
        .i_data  ({InTag, InFunc, InB, InA}),
        .o_valid (w_s1_valid),
        .i_ready (w_s2_ready),
        .o_data  (w_s1_q)
    );

    assign {w_s1_tag, w_s1_func, w_s1_b, w_s1_a} = w_s1_q;

    assign AluA      = w_s1_a;
    assign AluB      = w_s1_b;
    assign AluA_or_L = (w_s1_func[FUNC_A_OR_L] == ALU_LOGIC) ? ALU_LOGIC : ALU_ARITH;
    assign AluS_or_U = w_s1_func[FUNC_S_OR_U];
    assign AluOpCode = w_s1_func[FUNC_OP_MSB:FUNC_OP_LSB];

    alu_dispatch_slice #(
        .PAYLOAD_W(S2_W)
    ) u_s2 (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .i_flush (Flush),
        .i_valid (w_s1_valid),
        .o_ready (w_s2_ready),
        .i_data  ({w_s1_tag, AluAnswer}),
        .o_valid (OutValid),
        .i_ready (OutReady),
        .o_data  (w_s2_q)
    );

    assign {OutTag, OutResult} = w_s2_q;

`ifdef ALU_DISPATCH_STATS_EN
    logic [31:0] r_issue_cnt;
    logic [31:0] r_stall_cnt;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_issue_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (InValid && InReady) begin
                r_issue_cnt <= r_issue_cnt + 32'd1;
            end
            if (OutValid && !OutReady) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign IssueCount = r_issue_cnt;
    assign StallCount = r_stall_cnt;
`endif

endmodule

// File: tb/tb_alu_dispatch.sv
// Self-checking bench for alu_dispatch: queue-based pipeline model plus directed literal checks.
module tb_alu_dispatch;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Flush = 1'b0;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [3:0]  InFunc = '0;
    logic [31:0] InA = '0;
    logic [31:0] InB = '0;
    logic [3:0]  InTag = '0;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic        AluA_or_L;
    logic        AluS_or_U;
    logic [1:0]  AluOpCode;
    logic [31:0] AluAnswer;
    logic        OutValid;
    logic        OutReady = 1'b1;
    logic [31:0] OutResult;
    logic [3:0]  OutTag;
`ifdef ALU_DISPATCH_STATS_EN
    logic [31:0] IssueCount;
    logic [31:0] StallCount;
`endif

    alu_dispatch #(.DATA_W(32), .TAG_W(4)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Flush     (Flush),
        .InValid   (InValid),
        .InReady   (InReady),
        .InFunc    (InFunc),
        .InA       (InA),
        .InB       (InB),
        .InTag     (InTag),
        .AluA      (AluA),
        .AluB      (AluB),
        .AluA_or_L (AluA_or_L),
        .AluS_or_U (AluS_or_U),
        .AluOpCode (AluOpCode),
        .AluAnswer (AluAnswer),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .OutResult (OutResult),
        .OutTag    (OutTag)
`ifdef ALU_DISPATCH_STATS_EN
        ,
        .IssueCount(IssueCount),
        .StallCount(StallCount)
`endif
    );

    // Stand-in Alu
    assign AluAnswer = AluA ^ AluB;

    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Model: the in-flight operations in accept order, each with the number of edges it has lived.
    typedef struct {
        logic [31:0] res;
        logic [3:0]  tag;
        int          age;
    } item_t;

    item_t       q[$];
    logic        m_rst_done = 1'b0;
    logic [31:0] m_a = '0;
    logic [31:0] m_b = '0;
    logic [3:0]  m_func = '0;
    logic [31:0] m_iss = '0;
    logic [31:0] m_stl = '0;

    logic        f_acc = 1'b0, f_cons = 1'b0, f_flush = 1'b0, f_stall = 1'b0;
    logic [31:0] f_a = '0, f_b = '0;
    logic [3:0]  f_func = '0, f_tag = '0;

    int          cyc_n = 0;
    logic [3:0]  log_tag[$];
    logic [31:0] log_res[$];
    int          log_cyc[$];

    always @(negedge Clk) begin
        logic exp_rdy;
        logic exp_ov;
        f_acc   = 1'b0;
        f_cons  = 1'b0;
        f_flush = 1'b0;
        f_stall = 1'b0;
        if (!Reset_n) begin
            chk("rst_in_ready", InReady, 0);
            chk("rst_out_valid", OutValid, 0);
            chk("rst_out_result", OutResult, 0);
            chk("rst_out_tag", OutTag, 0);
            chk("rst_alu_a", AluA, 0);
            chk("rst_alu_b", AluB, 0);
            chk("rst_alu_func", {AluA_or_L, AluS_or_U, AluOpCode}, 0);
        end else begin
            // Capacity two: a new request is refused only when both slots are full and the head is stalled.
            exp_rdy = m_rst_done && !Flush && !(q.size() == 2 && !OutReady);
            exp_ov  = (q.size() > 0) && (q[0].age >= 1);
            chk("in_ready", InReady, exp_rdy);
            chk("out_valid", OutValid, exp_ov);
            if (exp_ov) begin
                chk("out_result", OutResult, q[0].res);
                chk("out_tag", OutTag, q[0].tag);
            end
            chk("alu_a", AluA, m_a);
            chk("alu_b", AluB, m_b);
            chk("alu_func", {AluA_or_L, AluS_or_U, AluOpCode}, m_func);
`ifdef ALU_DISPATCH_STATS_EN
            chk("issue_count", IssueCount, m_iss);
            chk("stall_count", StallCount, m_stl);
`endif
            f_acc   = InValid && exp_rdy;
            f_cons  = exp_ov && OutReady && !Flush;
            f_flush = Flush;
            f_stall = exp_ov && !OutReady;
            f_a     = InA;
            f_b     = InB;
            f_func  = InFunc;
            f_tag   = InTag;
            if (f_cons) begin
                log_tag.push_back(OutTag);
                log_res.push_back(OutResult);
                log_cyc.push_back(cyc_n);
            end
        end
    end

    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q.delete();
            m_rst_done = 1'b0;
            m_a = '0;
            m_b = '0;
            m_func = '0;
            m_iss = '0;
            m_stl = '0;
        end else begin
            cyc_n++;
            if (f_flush) begin
                q.delete();
            end else begin
                if (f_cons) void'(q.pop_front());
                foreach (q[i]) q[i].age++;
                if (f_acc) q.push_back('{res: f_a ^ f_b, tag: f_tag, age: 0});
            end
            if (f_acc) begin
                m_a = f_a;
                m_b = f_b;
                m_func = f_func;
                m_iss = m_iss + 32'd1;
            end
            if (f_stall) m_stl = m_stl + 32'd1;
            m_rst_done = 1'b1;
        end
        f_acc   = 1'b0;
        f_cons  = 1'b0;
        f_flush = 1'b0;
        f_stall = 1'b0;
    end

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    int ready_waits = 0;

    // Offers one request and returns just after the edge that accepts it; InValid is left high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] f,
                        input logic [3:0] t);
        logic got;
        got = 1'b0;
        InValid = 1'b1;
        InA = a;
        InB = b;
        InFunc = f;
        InTag = t;
        for (int k = 0; k < 40; k++) begin
            @(negedge Clk);
            if (InReady) begin
                got = 1'b1;
                break;
            end
            ready_waits++;
        end
        chk("send_accepted", got, 1);
        cyc();
    endtask

    task automatic clear_log();
        log_tag.delete();
        log_res.delete();
        log_cyc.delete();
    endtask

    initial begin
        int idx;
        logic [31:0] bp_a[3];
        logic [31:0] bp_b[3];

        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        cyc();

        // Basic
        clear_log();
        OutReady = 1'b1;
        send(32'h0000_00F0, 32'h0000_000F, 4'b1010, 4'd3);
        InValid = 1'b0;
        @(negedge Clk);
        chk("basic_s1_func", {AluA_or_L, AluS_or_U, AluOpCode}, 4'b1010);
        chk("basic_s1_a", AluA, 32'h0000_00F0);
        chk("basic_not_yet_valid", OutValid, 0);
        @(negedge Clk);
        chk("basic_valid", OutValid, 1);
        chk("basic_result", OutResult, 32'h0000_00FF);
        chk("basic_tag", OutTag, 4'd3);
        cyc();
        repeat (2) cyc();

        // Streaming
        clear_log();
        ready_waits = 0;
        for (int i = 0; i < 8; i++) begin
            send(32'h1111_1111 * i, 32'h0F0F_0F0F, 4'(i), 4'(i));
        end
        InValid = 1'b0;
        repeat (5) cyc();
        chk("stream_ready_drops", ready_waits, 0);
        chk("stream_count", log_tag.size(), 8);
        for (int i = 0; i < 8; i++) begin
            if (i < log_tag.size()) begin
                chk("stream_tag", log_tag[i], i);
                chk("stream_consecutive", log_cyc[i] - log_cyc[0], i);
            end
        end

        // Backpressure
        clear_log();
        bp_a[0] = 32'hA5A5_0000; bp_b[0] = 32'h0000_5A5A;
        bp_a[1] = 32'h0000_0001; bp_b[1] = 32'h0000_0003;
        bp_a[2] = 32'hFFFF_FFFF; bp_b[2] = 32'h0000_0000;
        OutReady = 1'b0;
        idx = 0;
        InValid = 1'b1;
        InA = bp_a[0];
        InB = bp_b[0];
        InFunc = 4'b0100;
        InTag = 4'd8;
        repeat (5) begin
            @(negedge Clk);
            if (InReady) idx++;
            cyc();
            if (idx < 3) begin
                InA = bp_a[idx];
                InB = bp_b[idx];
                InTag = 4'(8 + idx);
            end
        end
        @(negedge Clk);
        chk("bp_accepted", idx, 2);
        chk("bp_in_ready", InReady, 0);
        chk("bp_out_tag", OutTag, 4'd8);
        chk("bp_out_result", OutResult, 32'hA5A5_5A5A);
        cyc();
        InValid = 1'b0;
        OutReady = 1'b1;
        repeat (4) cyc();
        chk("bp_delivered", log_tag.size(), 2);
        if (log_tag.size() >= 2) begin
            chk("bp_tag0", log_tag[0], 4'd8);
            chk("bp_tag1", log_tag[1], 4'd9);
            chk("bp_res1", log_res[1], 32'h0000_0002);
        end

        // Flush
        clear_log();
        OutReady = 1'b0;
        send(32'h0000_0010, 32'h0000_0001, 4'b0001, 4'd10);
        send(32'h0000_0020, 32'h0000_0002, 4'b0010, 4'd11);
        InValid = 1'b0;
        repeat (2) cyc();
        InValid = 1'b1;
        InA = 32'hDEAD_0000;
        InB = 32'h0000_BEEF;
        InFunc = 4'b1111;
        InTag = 4'd12;
        OutReady = 1'b1;
        Flush = 1'b1;
        @(negedge Clk);
        chk("flush_in_ready", InReady, 0);
        cyc();
        Flush = 1'b0;
        InValid = 1'b0;
        @(negedge Clk);
        chk("flush_out_valid", OutValid, 0);
        chk("flush_alu_a_kept", AluA, 32'h0000_0020);
        repeat (3) cyc();
        chk("flush_nothing_out", log_tag.size(), 0);
        send(32'h1234_0000, 32'h0000_5678, 4'b0111, 4'd13);
        InValid = 1'b0;
        repeat (4) cyc();
        chk("flush_after_count", log_tag.size(), 1);
        if (log_tag.size() >= 1) begin
            chk("flush_after_tag", log_tag[0], 4'd13);
            chk("flush_after_res", log_res[0], 32'h1234_5678);
        end

        // Reset mid-stream
        OutReady = 1'b1;
        send(32'h0000_0001, 32'h0000_0002, 4'b0011, 4'd1);
        send(32'h0000_0003, 32'h0000_0004, 4'b0011, 4'd2);
        clear_log();
        #2 Reset_n = 1'b0;
        #1;
        chk("rst_async_out_valid", OutValid, 0);
        chk("rst_async_alu_a", AluA, 0);
        chk("rst_async_alu_b", AluB, 0);
        chk("rst_async_in_ready", InReady, 0);
        repeat (2) cyc();
        Reset_n = 1'b1;
        InValid = 1'b0;
        repeat (5) cyc();
        chk("rst_no_stale", log_tag.size(), 0);
        send(32'hFFFF_0000, 32'h00FF_00FF, 4'b1101, 4'd5);
        InValid = 1'b0;
        repeat (4) cyc();
        chk("rst_after_count", log_tag.size(), 1);
        if (log_tag.size() >= 1) begin
            chk("rst_after_res", log_res[0], 32'hFF00_00FF);
            chk("rst_after_tag", log_tag[0], 4'd5);
        end

`ifdef ALU_DISPATCH_STATS_EN
        Reset_n = 1'b0;
        cyc();
        Reset_n = 1'b1;
        cyc();
        OutReady = 1'b1;
        send(32'h0000_0100, 32'h0000_0001, 4'b0000, 4'd0);
        InValid = 1'b0;
        OutReady = 1'b0;
        cyc();
        repeat (4) cyc();
        OutReady = 1'b1;
        for (int i = 1; i < 10; i++) begin
            send(32'h0000_1000 + i, 32'h0000_0000, 4'b0000, 4'(i));
        end
        InValid = 1'b0;
        repeat (4) cyc();
        @(negedge Clk);
        chk("stats_issue", IssueCount, 32'd10);
        chk("stats_stall", StallCount, 32'd4);
        cyc();
        Flush = 1'b1;
        cyc();
        Flush = 1'b0;
        @(negedge Clk);
        chk("stats_issue_flush", IssueCount, 32'd10);
        chk("stats_stall_flush", StallCount, 32'd4);
        cyc();
`endif

        repeat (2) cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

endmodule
